// File: rtl/manchester_frame_receiver_pkg.sv
// ---------------------------------------------------------------------------
// manchester_frame_pkg - shared states, error codes and CRC-8 helper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package manchester_frame_pkg;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CRC  = 3'd1;
  localparam logic [2:0] ERR_LEN  = 3'd2;
  localparam logic [2:0] ERR_DEC  = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;
  localparam logic [2:0] ERR_OVF  = 3'd5;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CRC     = 2'd3
  } state_t;

  // MSB-first, unreflected, no final XOR
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/manchester_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// manchester_frame_receiver_if - byte-strobe input and payload/status output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface manchester_frame_receiver_if;
  logic [7:0] byte_i;
  logic       byte_valid_i;
  logic       byte_err_i;
  logic [7:0] payload_o;
  logic       payload_last_o;
  logic       payload_valid_o;
  logic       payload_ready_i;
  logic       frame_done_o;
  logic       frame_ok_o;
  logic [2:0] err_code_o;
  logic       busy_o;

  modport slave (
    input  byte_i, byte_valid_i, byte_err_i, payload_ready_i,
    output payload_o, payload_last_o, payload_valid_o,
           frame_done_o, frame_ok_o, err_code_o, busy_o
  );

  modport master (
    output byte_i, byte_valid_i, byte_err_i, payload_ready_i,
    input  payload_o, payload_last_o, payload_valid_o,
           frame_done_o, frame_ok_o, err_code_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/manchester_frame_receiver_fifo.sv
// ---------------------------------------------------------------------------
// frame_sync_fifo - single-clock payload FIFO with wrap-bit pointers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  wire logic             clk16x,
  input  wire logic             resetn,
  input  wire logic             i_push,
  input  wire logic [WIDTH-1:0] i_data,
  input  wire logic             i_pop,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk16x) begin
    if (!resetn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/manchester_frame_receiver.sv
// ---------------------------------------------------------------------------
// manchester_frame_receiver - sync hunt, LEN/payload/CRC-8 parse, payload FIFO
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module manchester_frame_receiver
  import manchester_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = 8'hD5,
  parameter int         MAX_LEN    = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter int         TIMEOUT    = 4096
) (
  input wire logic                    clk16x,
  input wire logic                    resetn,
  manchester_frame_receiver_if.slave  bus
);

  localparam int IW = $clog2(TIMEOUT);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_crc, w_crc_nxt;
  logic [7:0]    r_cnt, w_cnt_nxt;
  logic          r_ovf;
  logic [IW-1:0] r_idle;
  logic          r_done, w_done_nxt;
  logic          r_ok, w_ok_nxt;
  logic [2:0]    r_err, w_err_nxt;
  logic          w_push, w_push_last, w_frame_start;
  logic          w_pop, w_full, w_empty, w_ovf_drop;
  logic [8:0]    w_head;

  assign w_pop      = bus.payload_ready_i && !w_empty;
  assign w_ovf_drop = w_push && w_full && !w_pop;

  always_comb begin
    w_state_nxt   = r_state;
    w_crc_nxt     = r_crc;
    w_cnt_nxt     = r_cnt;
    w_done_nxt    = 1'b0;
    w_ok_nxt      = 1'b0;
    w_err_nxt     = ERR_NONE;
    w_push        = 1'b0;
    w_push_last   = 1'b0;
    w_frame_start = 1'b0;
    if (r_state == ST_HUNT) begin
      if (bus.byte_valid_i && bus.byte_i == SYNC_BYTE) w_state_nxt = ST_LEN;
    end else if (bus.byte_err_i) begin
      w_done_nxt  = 1'b1;
      w_err_nxt   = ERR_DEC;
      w_state_nxt = ST_HUNT;
    end else if (bus.byte_valid_i) begin
      case (r_state)
        ST_LEN: begin
          if (bus.byte_i == 8'd0 || bus.byte_i > 8'(MAX_LEN)) begin
            w_done_nxt  = 1'b1;
            w_err_nxt   = ERR_LEN;
            w_state_nxt = ST_HUNT;
          end else begin
            w_crc_nxt     = crc8_byte(8'h00, bus.byte_i);
            w_cnt_nxt     = bus.byte_i;
            w_frame_start = 1'b1;
            w_state_nxt   = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          w_crc_nxt   = crc8_byte(r_crc, bus.byte_i);
          w_push      = 1'b1;
          w_push_last = (r_cnt == 8'd1);
          w_cnt_nxt   = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_state_nxt = ST_CRC;
        end
        default: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_HUNT;
          if (r_ovf)                     w_err_nxt = ERR_OVF;
          else if (bus.byte_i == r_crc)  w_ok_nxt  = 1'b1;
          else                           w_err_nxt = ERR_CRC;
        end
      endcase
    end else if (r_idle == IW'(TIMEOUT - 1)) begin
      w_done_nxt  = 1'b1;
      w_err_nxt   = ERR_TMO;
      w_state_nxt = ST_HUNT;
    end
  end

  always_ff @(posedge clk16x) begin
    if (!resetn) begin
      r_state <= ST_HUNT;
      r_crc   <= 8'h00;
      r_cnt   <= 8'h00;
      r_ovf   <= 1'b0;
      r_idle  <= '0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      if (w_frame_start)   r_ovf <= 1'b0;
      else if (w_ovf_drop) r_ovf <= 1'b1;
      if (r_state == ST_HUNT || bus.byte_valid_i) r_idle <= '0;
      else                                        r_idle <= r_idle + 1'b1;
    end
  end

  frame_sync_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk16x  (clk16x),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  ({w_push_last, bus.byte_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.payload_o       = w_head[7:0];
  assign bus.payload_last_o  = w_head[8];
  assign bus.payload_valid_o = !w_empty;
  assign bus.frame_done_o    = r_done;
  assign bus.frame_ok_o      = r_ok;
  assign bus.err_code_o      = r_err;
  assign bus.busy_o          = (r_state != ST_HUNT);

endmodule

`default_nettype wire

// File: tb/tb_manchester_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_manchester_frame_receiver - directed frames with a queue scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_manchester_frame_receiver;

  localparam int TIMEOUT = 4096;

  logic clk16x = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [8:0] exp_pay [$];
  logic [3:0] exp_st  [$];

  manchester_frame_receiver_if bus ();

  manchester_frame_receiver #(
    .SYNC_BYTE  (8'hD5),
    .MAX_LEN    (32),
    .FIFO_DEPTH (16),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk16x (clk16x),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk16x = ~clk16x;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents output
  always @(negedge clk16x) begin
    logic [8:0] ep;
    logic [3:0] es;
    if (bus.payload_valid_o && bus.payload_ready_i) begin
      if (exp_pay.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL payload_unexpected actual=%0h required=none", {bus.payload_last_o, bus.payload_o});
      end else begin
        ep = exp_pay.pop_front();
        check("payload", {23'd0, bus.payload_last_o, bus.payload_o}, {23'd0, ep});
      end
    end
    if (bus.frame_done_o) begin
      if (exp_st.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL status_unexpected actual=%0h required=none", {bus.frame_ok_o, bus.err_code_o});
      end else begin
        es = exp_st.pop_front();
        check("status", {28'd0, bus.frame_ok_o, bus.err_code_o}, {28'd0, es});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk16x);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.byte_i       = b;
    bus.byte_valid_i = 1'b1;
    @(posedge clk16x);
    #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    strobe(b);
    idle(gap);
  endtask

  function automatic logic [7:0] crc_bitwise(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic good_frame(input int gap);
    send(8'hD5, gap);
    send(8'h01, gap);
    exp_pay.push_back({1'b1, 8'hAC});
    send(8'hAC, gap);
    exp_st.push_back({1'b1, 3'd0});
    send(8'h58, gap);
  endtask

  initial begin
    logic [7:0] crc;
    bus.byte_i          = 8'h00;
    bus.byte_valid_i    = 1'b0;
    bus.byte_err_i      = 1'b0;
    bus.payload_ready_i = 1'b1;
    idle(3);
    check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
    check("rst_valid", {31'd0, bus.payload_valid_o}, 32'd0);
    check("rst_done",  {31'd0, bus.frame_done_o}, 32'd0);
    check("rst_outs",  {20'd0, bus.frame_ok_o, bus.err_code_o, bus.payload_o}, 32'd0);
    resetn = 1'b1;
    idle(2);

    // Good frame at 256-cycle spacing, busy drops right after the CRC strobe
    send(8'hD5, 255);
    send(8'h01, 255);
    exp_pay.push_back({1'b1, 8'hAC});
    send(8'hAC, 255);
    check("t1_busy_before", {31'd0, bus.busy_o}, 32'd1);
    exp_st.push_back({1'b1, 3'd0});
    strobe(8'h58);
    check("t1_busy_after", {31'd0, bus.busy_o}, 32'd0);
    check("t1_done",       {31'd0, bus.frame_done_o}, 32'd1);
    idle(255);

    // Bad CRC, then good frame
    send(8'hD5, 15);
    send(8'h01, 15);
    exp_pay.push_back({1'b1, 8'hAC});
    send(8'hAC, 15);
    exp_st.push_back({1'b0, 3'd1});
    send(8'h59, 15);
    good_frame(15);

    // Bad LEN: zero and too long
    send(8'h00, 7);
    send(8'hD5, 7);
    exp_st.push_back({1'b0, 3'd2});
    send(8'h00, 7);
    check("t3_len0_empty", {31'd0, bus.payload_valid_o}, 32'd0);
    send(8'hD5, 7);
    exp_st.push_back({1'b0, 3'd2});
    send(8'h21, 7);
    check("t3_len33_empty", {31'd0, bus.payload_valid_o}, 32'd0);
    check("t3_busy", {31'd0, bus.busy_o}, 32'd0);

    // Decoder error mid-payload
    send(8'hD5, 7);
    send(8'h02, 7);
    exp_pay.push_back({1'b0, 8'h11});
    send(8'h11, 7);
    exp_st.push_back({1'b0, 3'd3});
    bus.byte_err_i = 1'b1;
    @(posedge clk16x);
    #1;
    bus.byte_err_i = 1'b0;
    check("t4_err_done", {31'd0, bus.frame_done_o}, 32'd1);
    idle(8);

    // Timeout exactly TIMEOUT cycles after the last strobe
    send(8'hD5, 7);
    send(8'h02, 7);
    exp_pay.push_back({1'b0, 8'h11});
    exp_st.push_back({1'b0, 3'd4});
    strobe(8'h11);
    idle(TIMEOUT - 1);
    check("t4_tmo_early", {31'd0, bus.frame_done_o}, 32'd0);
    idle(1);
    check("t4_tmo_done", {31'd0, bus.frame_done_o}, 32'd1);
    idle(4);

    // Overflow with downstream stalled, then drain in order
    bus.payload_ready_i = 1'b0;
    idle(2);
    send(8'hD5, 3);
    send(8'h12, 3);
    crc = crc_bitwise(8'h00, 8'h12);
    for (int i = 0; i < 18; i++) begin
      crc = crc_bitwise(crc, 8'h20 + 8'(i));
      if (i < 16) exp_pay.push_back({1'b0, 8'h20 + 8'(i)});
      send(8'h20 + 8'(i), 3);
    end
    exp_st.push_back({1'b0, 3'd5});
    send(crc, 3);
    check("t5_full_valid", {31'd0, bus.payload_valid_o}, 32'd1);
    bus.payload_ready_i = 1'b1;
    idle(24);
    check("t5_drained", exp_pay.size(), 32'd0);
    check("t5_empty", {31'd0, bus.payload_valid_o}, 32'd0);

    // Reset mid-payload discards everything silently
    bus.payload_ready_i = 1'b0;
    send(8'hD5, 3);
    send(8'h03, 3);
    send(8'h44, 3);
    check("t6_stored", {31'd0, bus.payload_valid_o}, 32'd1);
    resetn = 1'b0;
    idle(1);
    check("t6_valid", {31'd0, bus.payload_valid_o}, 32'd0);
    check("t6_busy",  {31'd0, bus.busy_o}, 32'd0);
    check("t6_outs",  {19'd0, bus.frame_done_o, bus.frame_ok_o, bus.err_code_o, bus.payload_last_o, bus.payload_o}, 32'd0);
    resetn = 1'b1;
    bus.payload_ready_i = 1'b1;
    idle(2);
    good_frame(5);

    idle(20);
    check("end_pay_queue", exp_pay.size(), 32'd0);
    check("end_st_queue",  exp_st.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/manchester_frame_receiver.md
Name: manchester_frame_receiver

Overview:
Receive-side framing layer for the VLC link. It consumes the byte stream from manchesterDecoder (data_o, dataValid_o, recvErr), hunts for a sync byte, then parses a length byte, the payload and a CRC-8 trailer. Payload bytes are buffered in a small FIFO and presented downstream with a valid/ready handshake. Each frame ends with a one-cycle status pulse. This block is the counterpart of the transmit-side framer that feeds manchesterEncoder.

Parameters:
SYNC_BYTE, 8'hD5, frame start delimiter
MAX_LEN, 32, largest legal payload length in bytes (1..255)
FIFO_DEPTH, 16, payload FIFO entries (power of 2, >=2)
TIMEOUT, 4096, maximum clk16x cycles between bytes inside a frame

Ports:
clk16x  in  1  sole clock; same 16x oversampling clock as encoder/decoder
resetn  in  1  synchronous reset, active low
byte_i  in  8  decoded byte (from decoder data_o)
byte_valid_i  in  1  one-cycle strobe, byte_i valid
byte_err_i  in  1  one-cycle decoder error strobe (recvErr)
payload_o  out  8  FIFO head byte
payload_last_o  out  1  head byte is the final payload byte of its frame
payload_valid_o  out  1  FIFO non-empty
payload_ready_i  in  1  downstream accepts head when valid&ready
frame_done_o  out  1  one-cycle pulse at end or abort of every frame
frame_ok_o  out  1  qualified by frame_done_o: 1 = CRC good and no error
err_code_o  out  3  qualified by frame_done_o: 0 none, 1 CRC, 2 bad LEN, 3 decoder err, 4 timeout, 5 FIFO overflow
busy_o  out  1  state != HUNT

Behaviour:
- Reset (resetn=0 at posedge): state=HUNT; FIFO emptied; all outputs 0 (payload_o 8'h00); CRC, counters and overflow flag cleared. A reset mid-frame discards the partial frame, with no frame_done_o.
- The input is a strobe interface with no backpressure. byte_i is sampled only when byte_valid_i=1.
- FSM:
  - HUNT: a byte equal to SYNC_BYTE goes to LEN. Any other byte is ignored. byte_err_i is ignored.
  - LEN: LEN=0 or LEN>MAX_LEN -> done, err 2, back to HUNT. Otherwise store LEN, crc=crc8(8'h00,LEN), cnt=LEN, go to PAYLOAD.
  - PAYLOAD: each byte updates crc, is pushed to the FIFO (last flag set when cnt==1) and decrements cnt. Go to CRC when cnt reaches 0.
  - CRC: byte==crc and no overflow during the frame -> done, ok=1, err 0. Byte!=crc -> err 1. Overflow -> err 5 (takes priority over CRC). Return to HUNT.
- Decoder error: byte_err_i in LEN/PAYLOAD/CRC -> done, ok=0, err 3, back to HUNT. If byte_valid_i and byte_err_i are asserted together, the error wins and the byte is dropped.
- Timeout: an idle counter resets on every byte_valid_i outside HUNT. When it reaches TIMEOUT-1 with no byte -> done, err 4, back to HUNT.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR. Covers LEN and the payload. The sync byte is not included.
- Payload is delivered before CRC verification. Consumers must gate on frame_done_o/frame_ok_o. Bytes of bad frames are not withdrawn from the FIFO.
- Latency: a payload byte is written on the posedge where byte_valid_i is seen. payload_valid_o rises the next cycle (registered FIFO flags). Status pulses occur 1 cycle after the CRC byte strobe.
- FIFO:
  - A push when full with no pop that cycle drops the byte and sets the frame overflow flag.
  - A push and pop in the same cycle while full both succeed.
  - A pop when empty is ignored.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - payload_o and payload_last_o hold while valid&!ready.
- frame_done_o is never asserted on two consecutive cycles. A SYNC_BYTE arriving on the cycle after done is accepted.

Decomposition:
- Package manchester_frame_pkg:
  - err_code constants (ERR_NONE..ERR_OVF)
  - state encoding (HUNT, LEN, PAYLOAD, CRC)
  - CRC8_POLY
  - function crc8_byte(crc, data)
- Sub-module frame_sync_fifo: 9-bit wide ({last, byte}), DEPTH parameter, push/pop/full/empty, same clk16x/resetn.

Test Plan:
- Frame D5 01 AC 58 strobed every 256 cycles -> payload AC with last=1. frame_done_o with ok=1, err 0. busy_o falls the cycle after the CRC strobe.
- Frame D5 01 AC 59 -> AC delivered, then done with ok=0, err 1. The next D5 01 AC 58 passes with ok=1.
- Bytes 00 D5 00 -> 00 ignored in HUNT, then done err 2. Also D5 21 (33 > MAX_LEN=32) -> err 2. FIFO stays empty in both cases.
- D5 02 11, then byte_err_i pulse -> done err 3, FIFO holds 11 with last=0. D5 02 11, then silence for 4096 cycles -> done err 4 at exactly cycle TIMEOUT after the last strobe.
- payload_ready_i=0 with a frame D5 12 (18 bytes) + correct CRC -> 16 stored, overflow, done err 5. Then release ready and confirm 16 bytes drain in order.
- resetn=0 mid-PAYLOAD -> next cycle all outputs 0, FIFO empty, no frame_done_o, state HUNT.
